// File: rtl/mem_image_streamer.sv
// Purpose : fetch one frame of 2^LOG2_N words from a 1-cycle synchronous-read
//           memory and stream them out on valid/ready with frame-last marking.
// Latency : start at cycle 0, first read at cycle 1, first out_valid at cycle 3;
//           then one sample per cycle, done pulses the cycle after the last accept.
// Backpressure: a 2-entry FIFO absorbs the memory latency; reads are issued only
//           when a FIFO slot is guaranteed, so out_ready low stalls reads within 2 words.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           one-cycle pulse, honoured only in IDLE
//   base_addr       frame start address, latched on accepted start
//   mem_addr        registered read address (base_addr + offset(idx), wraps)
//   mem_rd_ena      read issued this cycle, data expected on mem_data next cycle
//   mem_data        memory read data
//   out_data/out_valid/out_ready/out_last   output sample stream
//   busy            frame in progress (FETCH or DRAIN)
//   done            one-cycle pulse after the final sample is accepted
//
// Build option: define BIT_REVERSE_EN to fetch in bit-reversed offset order
// (DIT FFT input ordering); otherwise offsets run 0..2^LOG2_N-1.
module mem_image_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LOG2_N     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_ena,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LOG2_N-1:0] IDX_LAST = '1;
  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LOG2_N-1:0]     idx;
  logic                  inflight;
  logic                  inflight_last;

  // Two-entry FIFO: head drives the output directly, tail holds the second word.
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [DATA_WIDTH-1:0] tail_dat;
  logic                  head_last;
  logic                  tail_last;

  logic                  pop;
  logic                  push;
  logic                  rd_ena;
  logic [2:0]            occupancy;

  function automatic logic [LOG2_N-1:0] offset_of(input logic [LOG2_N-1:0] i);
    logic [LOG2_N-1:0] r;
    r = i;
`ifdef BIT_REVERSE_EN
    for (int b = 0; b < LOG2_N; b++) begin
      r[b] = i[LOG2_N-1-b];
    end
`endif
    return r;
  endfunction

  assign pop  = (fifo_count != 2'd0) && out_ready;
  assign push = inflight;

  // Slots committed for the next cycle: stored words plus the word in flight,
  // less the word leaving this cycle. A slot freed by a same-cycle pop can be
  // reused immediately, which is what sustains one sample per cycle; the FIFO
  // still never holds more than 2 words.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_ena    = (state == S_FETCH) && (occupancy < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      base_q        <= '0;
      addr_q        <= '0;
      idx           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_ena;
      inflight_last <= rd_ena && (idx == IDX_LAST);
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FETCH;
            base_q <= base_addr;
            addr_q <= base_addr;  // offset of idx 0 is 0 in both orders
            idx    <= '0;
          end
        end
        S_FETCH: begin
          if (rd_ena) begin
            idx <= idx + IDX_ONE;
            if (idx == IDX_LAST) begin
              state <= S_DRAIN;
            end else begin
              addr_q <= base_q + ADDR_WIDTH'(offset_of(idx + IDX_ONE));
            end
          end
        end
        S_DRAIN: begin
          if (pop && head_last) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= 2'd0;
      head_dat   <= '0;
      tail_dat   <= '0;
      head_last  <= 1'b0;
      tail_last  <= 1'b0;
    end else begin
      if (push && pop) begin
        if (fifo_count == 2'd2) begin
          head_dat  <= tail_dat;
          head_last <= tail_last;
          tail_dat  <= mem_data;
          tail_last <= inflight_last;
        end else begin
          head_dat  <= mem_data;
          head_last <= inflight_last;
        end
      end else if (push) begin
        if (fifo_count == 2'd0) begin
          head_dat  <= mem_data;
          head_last <= inflight_last;
        end else begin
          tail_dat  <= mem_data;
          tail_last <= inflight_last;
        end
        fifo_count <= fifo_count + 2'd1;
      end else if (pop) begin
        head_dat   <= tail_dat;
        head_last  <= tail_last;
        fifo_count <= fifo_count - 2'd1;
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd_ena = rd_ena;
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head_dat;
  assign out_last   = out_valid && head_last;
  assign busy       = (state == S_FETCH) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mem_image_streamer.sv
module tb_mem_image_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] mem_addr;
  logic        mem_rd_ena;
  logic [31:0] mem_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  mem_image_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mem_addr   (mem_addr),
    .mem_rd_ena (mem_rd_ena),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: tagged address returned one cycle after the read.
  always @(posedge clk) begin
    if (mem_rd_ena) mem_data <= 32'hA500_0000 | 32'(mem_addr);
  end

  int checks;
  int failures;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-frame observations.
  logic [31:0] got_dat [16];
  logic [11:0] rd_addr [16];
  logic [63:0] busy_mask;
  int acc_n, rd_n, done_n, last_n, last_pos;
  int first_acc, last_acc, first_rd, done_cyc;
  int stall_err, rule_err;

  function automatic logic [11:0] off_of(input int i);
`ifdef BIT_REVERSE_EN
    return 12'({i[0], i[1], i[2]});
`else
    return 12'(i);
`endif
  endfunction

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,0 repeating.
  task automatic run_frame(input logic [11:0] base, input int mode,
                           input int abort_after, input int start2);
    int cnt_m, infl_m, abort_c;
    bit prev_stall, aborted, p;
    logic [31:0] prev_dat;
    logic prev_last;
    acc_n = 0; rd_n = 0; done_n = 0; last_n = 0; last_pos = -1;
    first_acc = -1; last_acc = -1; first_rd = -1; done_cyc = -1;
    stall_err = 0; rule_err = 0; busy_mask = '0;
    cnt_m = 0; infl_m = 0; prev_stall = 0; aborted = 0; abort_c = 0;
    prev_dat = '0; prev_last = 1'b0;
    for (int c = 0; c < 150; c++) begin
      start     = (c == 0) || (c == start2);
      base_addr = (c == 0) ? base : 12'hABC;
      out_ready = (mode == 0) ? 1'b1 : ((c % 5 == 0) || (c % 5 == 3));
      #1;
      p = out_valid && out_ready;
      if (prev_stall && !(out_valid && out_data == prev_dat && out_last == prev_last))
        stall_err++;
      if (mem_rd_ena && (cnt_m + infl_m - int'(p)) >= 2) rule_err++;
      if (out_valid != (cnt_m > 0)) rule_err++;
      if (mem_rd_ena) begin
        if (rd_n < 16) rd_addr[rd_n] = mem_addr;
        if (rd_n == 0) first_rd = c;
        rd_n++;
      end
      if (p) begin
        if (acc_n < 16) got_dat[acc_n] = out_data;
        if (acc_n == 0) first_acc = c;
        last_acc = c;
        if (out_last) begin
          last_n++;
          last_pos = acc_n;
        end
        acc_n++;
      end
      if (busy && c < 64) busy_mask[c] = 1'b1;
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      cnt_m      = cnt_m + infl_m - int'(p);
      infl_m     = int'(mem_rd_ena);
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
      if (abort_after > 0 && !aborted && acc_n == abort_after) begin
        aborted = 1;
        abort_c = c;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check_val("abort_ctrl", 32'({mem_rd_ena, out_valid, out_last, busy, done}), 32'd0);
        check_val("abort_addr", 32'(mem_addr), 32'd0);
        check_val("abort_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0; infl_m = 0; prev_stall = 0;
      end
      if (done_n > 0 && c >= done_cyc + 3) break;
      if (aborted && c >= abort_c + 10) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [11:0] base);
    logic [11:0] a;
    check_val({tag, "_count"}, 32'(acc_n), 32'd8);
    check_val({tag, "_done_n"}, 32'(done_n), 32'd1);
    check_val({tag, "_last_n"}, 32'(last_n), 32'd1);
    check_val({tag, "_last_pos"}, 32'(last_pos), 32'd7);
    check_val({tag, "_stall"}, 32'(stall_err), 32'd0);
    check_val({tag, "_rdrule"}, 32'(rule_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a = base + off_of(i);
      check_val($sformatf("%s_addr%0d", tag, i), 32'(rd_addr[i]), 32'(a));
      check_val($sformatf("%s_dat%0d", tag, i), got_dat[i], 32'hA500_0000 | 32'(a));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ctrl", 32'({mem_rd_ena, out_valid, out_last, busy, done}), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_busy", 32'({busy, out_valid, mem_rd_ena}), 32'd0);

    // Natural frame, timing reference.
    run_frame(12'd1, 0, 0, -1);
    check_frame("nat", 12'd1);
    check_val("nat_first_rd", 32'(first_rd), 32'd1);
    check_val("nat_first_acc", 32'(first_acc), 32'd3);
    check_val("nat_last_acc", 32'(last_acc), 32'd10);
    check_val("nat_done_cyc", 32'(done_cyc), 32'd11);
    check_val("nat_busy_mask", busy_mask[31:0], 32'h0000_07FE);

    // Backpressure.
    run_frame(12'd1, 1, 0, -1);
    check_frame("bp", 12'd1);

    // Address wrap.
    run_frame(12'd4093, 0, 0, -1);
    check_frame("wrap", 12'd4093);

    // Reset after 3 accepted samples, then clean restart.
    run_frame(12'd1, 0, 3, -1);
    check_val("abort_acc", 32'(acc_n), 32'd3);
    check_val("abort_no_done", 32'(done_n), 32'd0);
    run_frame(12'd0, 0, 0, -1);
    check_frame("restart", 12'd0);

    // Second start at cycle 5 ignored.
    run_frame(12'd1, 0, 0, 5);
    check_frame("dbl_start", 12'd1);
    check_val("dbl_done_cyc", 32'(done_cyc), 32'd11);

    // Base 16 (bit-reversed order in the BIT_REVERSE_EN build).
    run_frame(12'd16, 0, 0, -1);
    check_frame("b16", 12'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
